// File: rtl/fpalu_add_issue.sv
// ---------------------------------------------------------------------------
// fpalu_add_issue
//
// Operand issue stage in front of the combinational single-precision adder.
// Operand pairs are queued in a small FIFO, then moved one at a time into a
// registered output slot that feeds the adder directly. While a pair is
// loaded, both operands are classified (zero / denormal, infinity, NaN) and
// a ready-made IEEE-754 result is registered next to them. Downstream logic
// uses that result instead of the adder's sum whenever `special` is set.
//
// Parameters:
//   DEPTH           FIFO entries (power of two, at least 2)
//   AW              log2(DEPTH)
//
// Ports:
//   clk             clock, all state changes on the rising edge
//   rst             asynchronous active-high reset
//   in_valid        producer offers an operand pair
//   in_ready        FIFO can accept a pair (not full)
//   in_a, in_b      IEEE-754 single-precision operands from the producer
//   out_valid       output slot holds a pair
//   out_ready       consumer takes the slot this cycle
//   a_out, b_out    registered operands, wired to the adder inputs
//   special         at least one operand is zero/denormal, inf or NaN
//   special_result  bypass result, 0 when special is 0
//   count           FIFO occupancy 0..DEPTH, output slot not included
// ---------------------------------------------------------------------------
module fpalu_add_issue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_a,
    input  logic [31:0]   in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   a_out,
    output logic [31:0]   b_out,
    output logic          special,
    output logic [31:0]   special_result,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [31:0] QNAN       = 32'h7FC0_0000;
    localparam logic [31:0] NEG_ZERO   = 32'h8000_0000;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          push;
    logic          load;
    logic [31:0]   head_a;
    logic [31:0]   head_b;
    logic          a_zero, a_inf, a_nan;
    logic          b_zero, b_inf, b_nan;
    logic          head_special;
    logic [31:0]   head_result;

    // in_ready is decoded only from the registered occupancy, so a pop in
    // the same cycle never makes room for a push while the FIFO is full.
    // The output slot refills from the head whenever it is empty or being
    // consumed, which gives one pair per cycle with out_ready held high.
    always_comb begin
        in_ready = (count != FULL_COUNT);
        push     = in_valid && in_ready;
        load     = (count != '0) && (!out_valid || out_ready);
        head_a   = mem[rd_ptr][63:32];
        head_b   = mem[rd_ptr][31:0];
    end

    // Classify both head operands by exponent and mantissa. Denormals count
    // as zero because the adder flushes them anyway. The resulting bypass
    // value follows a fixed priority: any NaN, then inf minus inf, then a
    // single infinity (a wins when both are the same infinity), then the
    // signed-zero rule, then pass-through of the non-zero operand.
    always_comb begin
        a_zero = (head_a[30:23] == 8'h00);
        a_inf  = (head_a[30:23] == 8'hFF) && (head_a[22:0] == '0);
        a_nan  = (head_a[30:23] == 8'hFF) && (head_a[22:0] != '0);
        b_zero = (head_b[30:23] == 8'h00);
        b_inf  = (head_b[30:23] == 8'hFF) && (head_b[22:0] == '0);
        b_nan  = (head_b[30:23] == 8'hFF) && (head_b[22:0] != '0);

        head_special = a_zero || a_inf || a_nan || b_zero || b_inf || b_nan;
        head_result  = '0;
        if (a_nan || b_nan) begin
            head_result = QNAN;
        end else if (a_inf && b_inf && (head_a[31] != head_b[31])) begin
            head_result = QNAN;
        end else if (a_inf) begin
            head_result = head_a;
        end else if (b_inf) begin
            head_result = head_b;
        end else if (a_zero && b_zero) begin
            head_result = (head_a[31] && head_b[31]) ? NEG_ZERO : 32'h0;
        end else if (a_zero) begin
            head_result = head_b;
        end else if (b_zero) begin
            head_result = head_a;
        end
    end

    // FIFO storage carries no reset; entries are only ever read after they
    // have been written, so stale contents after a reset are harmless.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    // Pointers wrap naturally at DEPTH. Occupancy moves by one on a lone
    // push or lone load and holds when both happen together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The output slot captures the head together with its classification,
    // then holds everything steady until the consumer takes it. When nothing
    // is queued, a taken slot simply goes invalid and keeps its old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            a_out          <= '0;
            b_out          <= '0;
            special        <= 1'b0;
            special_result <= '0;
        end else if (load) begin
            out_valid      <= 1'b1;
            a_out          <= head_a;
            b_out          <= head_b;
            special        <= head_special;
            special_result <= head_result;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpalu_add_issue.sv
// ---------------------------------------------------------------------------
// tb_fpalu_add_issue
//
// Self-checking bench for fpalu_add_issue. A queue-based reference model
// tracks the FIFO contents and the output slot and is compared against every
// DUT output after every clock. Directed scenarios cover a single pair,
// backpressure with pointer wrap, the listed special results, simultaneous
// push and load, and an asynchronous reset in mid-stream; a randomized run
// with a biased operand mix follows.
// ---------------------------------------------------------------------------
module tb_fpalu_add_issue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_a = '0;
    logic [31:0]   in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   a_out;
    logic [31:0]   b_out;
    logic          special;
    logic [31:0]   special_result;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    logic [63:0]   m_fifo[$];
    logic          m_valid;
    logic [31:0]   m_a;
    logic [31:0]   m_b;
    logic          m_special;
    logic [31:0]   m_result;

    fpalu_add_issue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .a_out          (a_out),
        .b_out          (b_out),
        .special        (special),
        .special_result (special_result),
        .count          (count)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // One comparison: counts it and reports tag, observed and expected on failure.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference bypass rule: categorise each operand, then walk the result
    // priority list as written for the issue stage.
    function automatic logic [32:0] ref_special(input logic [31:0] a, input logic [31:0] b);
        int  cat_a;
        int  cat_b;
        int  ea;
        int  eb;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        // 0 normal, 1 zero, 2 inf, 3 nan
        cat_a = (ea == 0) ? 1 : (ea == 255) ? ((a[22:0] == 0) ? 2 : 3) : 0;
        cat_b = (eb == 0) ? 1 : (eb == 255) ? ((b[22:0] == 0) ? 2 : 3) : 0;
        if (cat_a == 0 && cat_b == 0) return {1'b0, 32'h0};
        if (cat_a == 3 || cat_b == 3) return {1'b1, 32'h7FC00000};
        if (cat_a == 2 && cat_b == 2)
            return (a[31] != b[31]) ? {1'b1, 32'h7FC00000} : {1'b1, a};
        if (cat_a == 2) return {1'b1, a};
        if (cat_b == 2) return {1'b1, b};
        if (cat_a == 1 && cat_b == 1)
            return (a[31] && b[31]) ? {1'b1, 32'h80000000} : {1'b1, 32'h0};
        if (cat_a == 1) return {1'b1, b};
        return {1'b1, a};
    endfunction

    // Operand generator biased towards the special categories.
    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r[30:23] = 8'h00;
            1: r[30:0]  = '0;
            2: begin r[30:23] = 8'hFF; r[22:0] = '0; end
            3: r[30:23] = 8'hFF;
            default: ;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_valid   = 1'b0;
        m_a       = '0;
        m_b       = '0;
        m_special = 1'b0;
        m_result  = '0;
    endtask

    task automatic compare_all(input string tag);
        check_output({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check_output({tag, ".a_out"}, a_out, m_a);
        check_output({tag, ".b_out"}, b_out, m_b);
        check_output({tag, ".special"}, 32'(special), 32'(m_special));
        check_output({tag, ".special_result"}, special_result, m_result);
        check_output({tag, ".count"}, 32'(count), m_fifo.size());
        check_output({tag, ".in_ready"}, 32'(in_ready), 32'(m_fifo.size() < DEPTH));
    endtask

    // One clock of stimulus: drive inputs, advance the model across the
    // edge from its pre-edge state, then compare everything just after it.
    task automatic apply_stimulus(input string tag, input logic v, input logic [31:0] a,
                                  input logic [31:0] b, input logic rdy);
        logic        do_push;
        logic        do_load;
        logic [63:0] head;
        logic [32:0] sr;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
        do_push = v && (m_fifo.size() < DEPTH);
        do_load = (m_fifo.size() > 0) && (!m_valid || rdy);
        @(posedge clk);
        if (do_load) begin
            head      = m_fifo.pop_front();
            m_a       = head[63:32];
            m_b       = head[31:0];
            sr        = ref_special(m_a, m_b);
            m_special = sr[32];
            m_result  = sr[31:0];
            m_valid   = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        if (do_push) m_fifo.push_back({a, b});
        #1;
        compare_all(tag);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) apply_stimulus("drain", 1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        model_reset();
        $display("[TB] start");

        // Power-on reset.
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        compare_all("reset");

        // Single pair: visible two edges after the push, gone one edge later.
        apply_stimulus("single0", 1'b1, 32'h3F800000, 32'h40000000, 1'b1);
        check_output("single.not_yet_valid", 32'(out_valid), 32'd0);
        apply_stimulus("single1", 1'b0, '0, '0, 1'b1);
        check_output("single.valid", 32'(out_valid), 32'd1);
        check_output("single.a", a_out, 32'h3F800000);
        check_output("single.b", b_out, 32'h40000000);
        check_output("single.special", 32'(special), 32'd0);
        check_output("single.count", 32'(count), 32'd0);
        apply_stimulus("single2", 1'b0, '0, '0, 1'b1);
        check_output("single.cleared", 32'(out_valid), 32'd0);

        // Backpressure: 6 pushes, 5 accepted; repeated to wrap the pointers.
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < 6; k++)
                apply_stimulus("bp_push", 1'b1, 32'h3F000000 + 32'(rep * 16 + k),
                               32'h41000000 + 32'(rep * 16 + k), 1'b0);
            check_output("bp.count_full", 32'(count), 32'd4);
            check_output("bp.in_ready_low", 32'(in_ready), 32'd0);
            check_output("bp.first_in_slot", a_out, 32'h3F000000 + 32'(rep * 16));
            for (int k = 0; k < 6; k++) apply_stimulus("bp_drain", 1'b0, '0, '0, 1'b1);
        end

        // Listed special results.
        apply_stimulus("sp_inf", 1'b1, 32'h7F800000, 32'hFF800000, 1'b1);
        apply_stimulus("sp_inf", 1'b0, '0, '0, 1'b1);
        check_output("sp.inf_diff.special", 32'(special), 32'd1);
        check_output("sp.inf_diff.result", special_result, 32'h7FC00000);
        apply_stimulus("sp_nan", 1'b1, 32'h7FC00001, 32'h3F800000, 1'b1);
        apply_stimulus("sp_nan", 1'b0, '0, '0, 1'b1);
        check_output("sp.nan.result", special_result, 32'h7FC00000);
        apply_stimulus("sp_nz", 1'b1, 32'h80000000, 32'h80000000, 1'b1);
        apply_stimulus("sp_nz", 1'b0, '0, '0, 1'b1);
        check_output("sp.negzero.result", special_result, 32'h80000000);
        apply_stimulus("sp_den", 1'b1, 32'h00000001, 32'h40400000, 1'b1);
        apply_stimulus("sp_den", 1'b0, '0, '0, 1'b1);
        check_output("sp.denorm.result", special_result, 32'h40400000);
        drain();

        // Simultaneous push and load at count=2, then at count=4.
        for (int k = 0; k < 3; k++)
            apply_stimulus("sim_fill", 1'b1, 32'h40800000 + 32'(k), 32'h40A00000 + 32'(k), 1'b0);
        check_output("sim.count2", 32'(count), 32'd2);
        apply_stimulus("sim_pl2", 1'b1, 32'h40800010, 32'h40A00010, 1'b1);
        check_output("sim.count_hold", 32'(count), 32'd2);
        check_output("sim.next_head", a_out, 32'h40800001);
        apply_stimulus("sim_fill", 1'b1, 32'h40800011, 32'h40A00011, 1'b0);
        apply_stimulus("sim_fill", 1'b1, 32'h40800012, 32'h40A00012, 1'b0);
        check_output("sim.count4", 32'(count), 32'd4);
        apply_stimulus("sim_pl4", 1'b1, 32'h40800013, 32'h40A00013, 1'b1);
        check_output("sim.refused_count3", 32'(count), 32'd3);
        drain();

        // Asynchronous reset between edges with count=3 and slot valid.
        for (int k = 0; k < 4; k++)
            apply_stimulus("rst_fill", 1'b1, 32'h42000000 + 32'(k), 32'h42800000 + 32'(k), 1'b0);
        check_output("rst.pre_count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_output("rst.async.out_valid", 32'(out_valid), 32'd0);
        check_output("rst.async.count", 32'(count), 32'd0);
        check_output("rst.async.special", 32'(special), 32'd0);
        check_output("rst.async.in_ready", 32'(in_ready), 32'd1);
        #1 rst = 1'b0;
        apply_stimulus("rst_after", 1'b1, 32'h43000000, 32'h43800000, 1'b1);
        apply_stimulus("rst_after", 1'b0, '0, '0, 1'b1);
        check_output("rst.fresh.valid", 32'(out_valid), 32'd1);
        check_output("rst.fresh.a", a_out, 32'h43000000);
        check_output("rst.fresh.b", b_out, 32'h43800000);
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++)
            apply_stimulus("rand", 1'($urandom_range(0, 1)), rand_operand(), rand_operand(),
                           1'($urandom_range(0, 3) != 0));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
